// File: rtl/mem_pkg.sv
// Shared definitions for the latency-aware x8086 memory controller.
package mem_pkg;

    localparam int unsigned MEM_LAT_MAX = 8;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD_WAIT,
        ACK
    } mem_state_e;

endpackage

// File: rtl/mem_cntrl_lat.sv
// x8086 bus to 8-bit synchronous memory with fixed read latency; byte or word
// accesses run as one or two byte phases and finish with a one-cycle ack.
module mem_cntrl_lat
    import mem_pkg::*;
#(
    parameter int unsigned AW  = 20,
    parameter int unsigned LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_word,
    input  logic          i_write,
    input  logic [15:0]   i_data,
    output logic          o_busy,
    output logic          o_ack,
    output logic [15:0]   o_data,
    input  logic [7:0]    i_mem_data,
    output logic [AW-1:0] o_mem_addr,
    output logic [7:0]    o_mem_data,
    output logic          o_mem_write
);

    localparam int unsigned CW = $clog2(LAT + 1);

    if (LAT < 1 || LAT > MEM_LAT_MAX) begin : g_bad_lat
        $error("mem_cntrl_lat: LAT must be in 1..%0d", MEM_LAT_MAX);
    end

    mem_state_e    state;
    logic          phase;
    logic [CW-1:0] cnt;
    logic [AW-1:0] addr;
    logic          word;
    logic [7:0]    data_hi;

    // High byte of a word lives at addr+1, wrapping modulo 2^AW.
    logic [AW-1:0] addr_hi;
    assign addr_hi = addr + AW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            phase       <= 1'b0;
            cnt         <= '0;
            addr        <= '0;
            word        <= 1'b0;
            data_hi     <= '0;
            o_busy      <= 1'b0;
            o_ack       <= 1'b0;
            o_data      <= '0;
            o_mem_addr  <= '0;
            o_mem_data  <= '0;
            o_mem_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_ack <= 1'b0;
                    if (i_req) begin
                        addr       <= i_addr;
                        word       <= i_word;
                        data_hi    <= i_data[15:8];
                        phase      <= 1'b0;
                        cnt        <= CW'(LAT);
                        o_busy     <= 1'b1;
                        o_mem_addr <= i_addr;
                        if (i_write) begin
                            o_mem_data  <= i_data[7:0];
                            o_mem_write <= 1'b1;
                            state       <= WR;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end
                end

                WR: begin
                    if (word && !phase) begin
                        phase       <= 1'b1;
                        o_mem_addr  <= addr_hi;
                        o_mem_data  <= data_hi;
                        o_mem_write <= 1'b1;
                    end else begin
                        o_mem_write <= 1'b0;
                        o_ack       <= 1'b1;
                        state       <= ACK;
                    end
                end

                RD_WAIT: begin
                    // cnt == 1 marks the last cycle of the latency window.
                    if (cnt == CW'(1)) begin
                        if (phase) begin
                            o_data[15:8] <= i_mem_data;
                        end else if (word) begin
                            o_data[7:0] <= i_mem_data;
                        end else begin
                            o_data <= {8'h00, i_mem_data};
                        end
                        if (word && !phase) begin
                            phase      <= 1'b1;
                            cnt        <= CW'(LAT);
                            o_mem_addr <= addr_hi;
                        end else begin
                            o_ack <= 1'b1;
                            state <= ACK;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                ACK: begin
                    o_ack  <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_cntrl_lat.sv
// Scoreboard bench for mem_cntrl_lat: three instances (LAT 1, 2, 8) share the
// request bus, each with its own latency-accurate memory model.
module tb_mem_cntrl_lat;

    localparam int AW   = 20;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          i_req       [NDUT];
    logic [AW-1:0] i_addr;
    logic          i_word;
    logic          i_write;
    logic [15:0]   i_data;
    logic          o_busy      [NDUT];
    logic          o_ack       [NDUT];
    logic [15:0]   o_data      [NDUT];
    logic [AW-1:0] o_mem_addr  [NDUT];
    logic [7:0]    o_mem_data  [NDUT];
    logic          o_mem_write [NDUT];

    int n_checks = 0;
    int n_fail   = 0;
    int cur      = 1;
    int acks     [NDUT] = '{default: 0};
    int accepted [NDUT] = '{default: 0};
    logic [15:0] model_data [NDUT] = '{default: 16'h0000};

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;
    typedef struct {
        logic [15:0] data;
        int          ack_n;
    } rsp_t;

    wr_t  wq[$];
    rsp_t sb[$];

    function automatic logic [7:0] mem_rd(input logic [AW-1:0] a);
        case (a)
            20'hFFFFF: mem_rd = 8'h34;
            20'h00000: mem_rd = 8'h12;
            20'h12345: mem_rd = 8'hA5;
            default:   mem_rd = a[7:0] ^ 8'h5A;
        endcase
    endfunction

    function automatic int lat_of(input int k);
        lat_of = (k == 0) ? 1 : ((k == 1) ? 2 : 8);
    endfunction

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        localparam int L = (k == 0) ? 1 : ((k == 1) ? 2 : 8);
        logic [7:0] md;

        mem_cntrl_lat #(.AW(AW), .LAT(L)) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_req       (i_req[k]),
            .i_addr      (i_addr),
            .i_word      (i_word),
            .i_write     (i_write),
            .i_data      (i_data),
            .o_busy      (o_busy[k]),
            .o_ack       (o_ack[k]),
            .o_data      (o_data[k]),
            .i_mem_data  (md),
            .o_mem_addr  (o_mem_addr[k]),
            .o_mem_data  (o_mem_data[k]),
            .o_mem_write (o_mem_write[k])
        );

        // Data visible in a cycle belongs to the address presented L-1 cycles earlier.
        if (L == 1) begin : g_l1
            assign md = mem_rd(o_mem_addr[k]);
        end else begin : g_ln
            logic [AW-1:0] hist [L-1];
            always @(posedge clk) begin
                hist[0] <= o_mem_addr[k];
                for (int i = 1; i < L - 1; i++) hist[i] <= hist[i-1];
            end
            assign md = mem_rd(hist[L-2]);
        end
    end

    always @(negedge clk) begin
        wr_t e;
        for (int k = 0; k < NDUT; k++) if (rst_n && o_ack[k]) acks[k]++;
        if (o_mem_write[cur] === 1'b1) begin
            n_checks++;
            if (wq.size() == 0) begin
                n_fail++;
                $display("FAIL wr_strobe: unexpected write addr=%h data=%h, none expected",
                         o_mem_addr[cur], o_mem_data[cur]);
            end else begin
                e = wq.pop_front();
                if (o_mem_addr[cur] !== e.addr || o_mem_data[cur] !== e.data) begin
                    n_fail++;
                    $display("FAIL wr_strobe: got addr=%h data=%h, expected addr=%h data=%h",
                             o_mem_addr[cur], o_mem_data[cur], e.addr, e.data);
                end
            end
        end
    end

    // Drives one request in the current idle cycle and follows it to its ack.
    task automatic access(input int k, input logic word, input logic write,
                          input logic [AW-1:0] addr, input logic [15:0] data, input bit hold);
        int            ack_n;
        int            lat;
        bit            got;
        bit            exp_wr;
        rsp_t          e;
        logic [15:0]   expd;
        logic [AW-1:0] a1;
        lat   = lat_of(k);
        a1    = addr + 20'd1;
        ack_n = write ? (word ? 3 : 2) : (word ? 2 * lat + 1 : lat + 1);
        if (write) begin
            wq.push_back('{addr, data[7:0]});
            if (word) wq.push_back('{a1, data[15:8]});
            expd = model_data[k];
        end else begin
            expd = word ? {mem_rd(a1), mem_rd(addr)} : {8'h00, mem_rd(addr)};
        end
        model_data[k] = expd;
        sb.push_back('{expd, ack_n});
        cur = k;

        n_checks++;
        if (o_busy[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_pre: dut%0d busy=%b before acceptance, expected 0", k, o_busy[k]);
        end
        i_addr = addr; i_word = word; i_write = write; i_data = data; i_req[k] = 1'b1;
        @(posedge clk); #1;
        accepted[k]++;
        if (!hold) i_req[k] = 1'b0;

        got = 1'b0;
        for (int n = 1; n <= ack_n + 20; n++) begin
            @(negedge clk);
            if (n <= ack_n) begin
                n_checks++;
                if (o_busy[k] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy: dut%0d cycle T+%0d busy=%b, expected 1", k, n, o_busy[k]);
                end
                exp_wr = write && (n <= (word ? 2 : 1));
                n_checks++;
                if (o_mem_write[k] !== exp_wr) begin
                    n_fail++;
                    $display("FAIL wr_timing: dut%0d cycle T+%0d write=%b, expected %b",
                             k, n, o_mem_write[k], exp_wr);
                end
            end
            if (hold) i_req[k] = (o_ack[k] === 1'b1) ? 1'b1 : 1'($urandom_range(0, 1));
            if (o_ack[k] === 1'b1) begin
                got = 1'b1;
                e = sb.pop_front();
                n_checks++;
                if (n !== e.ack_n) begin
                    n_fail++;
                    $display("FAIL ack_cycle: dut%0d ack at T+%0d, expected T+%0d", k, n, e.ack_n);
                end
                n_checks++;
                if (o_data[k] !== e.data) begin
                    n_fail++;
                    $display("FAIL data: dut%0d o_data=%h, expected %h", k, o_data[k], e.data);
                end
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            void'(sb.pop_front());
            $display("FAIL ack_timeout: dut%0d no ack within T+%0d, expected T+%0d", k, ack_n + 20, ack_n);
        end
        @(posedge clk); #1;
        if (hold) i_req[k] = 1'b0;
        n_checks++;
        if (o_ack[k] !== 1'b0 || o_busy[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL post_ack: dut%0d ack=%b busy=%b, expected 0 0", k, o_ack[k], o_busy[k]);
        end
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (o_busy[k] !== 1'b0 || o_ack[k] !== 1'b0 || o_data[k] !== 16'h0000 ||
                o_mem_addr[k] !== 20'h00000 || o_mem_data[k] !== 8'h00 || o_mem_write[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s: dut%0d busy=%b ack=%b data=%h maddr=%h mdata=%h mwr=%b, expected all 0",
                         tag, k, o_busy[k], o_ack[k], o_data[k], o_mem_addr[k], o_mem_data[k], o_mem_write[k]);
            end
        end
    endtask

    task automatic check_idle(input int k, input int cycles);
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            n_checks++;
            if (o_busy[k] !== 1'b0 || o_ack[k] !== 1'b0 || o_mem_write[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL idle: dut%0d busy=%b ack=%b mwr=%b, expected 0 0 0",
                         k, o_busy[k], o_ack[k], o_mem_write[k]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < NDUT; k++) i_req[k] = 1'b0;
        i_addr = '0; i_word = 1'b0; i_write = 1'b0; i_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_byte_read();
        access(1, 1'b0, 1'b0, 20'h12345, 16'h0000, 1'b0);
    endtask

    task automatic test_word_write();
        access(1, 1'b1, 1'b1, 20'h00010, 16'hBEEF, 1'b0);
    endtask

    task automatic test_word_read_wrap();
        for (int k = 0; k < NDUT; k++) access(k, 1'b1, 1'b0, 20'hFFFFF, 16'h0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        access(1, 1'b1, 1'b0, 20'hFFFFF, 16'h0000, 1'b0);
        access(1, 1'b0, 1'b0, 20'h00020, 16'h0000, 1'b0);
        access(1, 1'b0, 1'b1, 20'h00030, 16'hAA55, 1'b0);
        access(1, 1'b1, 1'b0, 20'h00041, 16'h0000, 1'b0);
        access(0, 1'b1, 1'b1, 20'hFFFFF, 16'h9876, 1'b0);
        access(0, 1'b0, 1'b0, 20'h000FF, 16'h0000, 1'b0);
    endtask

    task automatic test_busy_ignore();
        access(1, 1'b1, 1'b1, 20'h00100, 16'h1234, 1'b1);
        check_idle(1, 3);
        access(2, 1'b1, 1'b0, 20'h00200, 16'h0000, 1'b1);
        check_idle(2, 3);
        for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (acks[k] !== accepted[k]) begin
                n_fail++;
                $display("FAIL ack_count: dut%0d acks=%0d, expected %0d", k, acks[k], accepted[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        cur = 1;
        wq.push_back('{20'h00300, 8'hFE});
        wq.push_back('{20'h00301, 8'hCA});
        i_addr = 20'h00300; i_word = 1'b1; i_write = 1'b1; i_data = 16'hCAFE; i_req[1] = 1'b1;
        @(posedge clk); #1;
        i_req[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (o_mem_write[1] !== 1'b1 || o_mem_addr[1] !== 20'h00301) begin
            n_fail++;
            $display("FAIL rst_mid_pre: mwr=%b maddr=%h, expected 1 00301", o_mem_write[1], o_mem_addr[1]);
        end
        #2 rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        for (int k = 0; k < NDUT; k++) model_data[k] = 16'h0000;
        repeat (2) @(negedge clk);
        check_zero("rst_hold");
        rst_n = 1'b1;
        @(posedge clk); #1;
        access(1, 1'b0, 1'b0, 20'h12345, 16'h0000, 1'b0);
        n_checks++;
        if (acks[1] !== accepted[1]) begin
            n_fail++;
            $display("FAIL rst_ack_count: dut1 acks=%0d, expected %0d", acks[1], accepted[1]);
        end
    endtask

    initial begin
        test_reset();
        test_byte_read();
        test_word_write();
        test_word_read_wrap();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        repeat (2) @(posedge clk);
        n_checks++;
        if (wq.size() != 0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d writes and %0d responses outstanding, expected 0 0", wq.size(), sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_cntrl_lat.md
# mem_cntrl_lat

Parametrised memory controller between the x8086 core bus and an 8-bit synchronous memory with fixed read latency. It accepts one request at a time and executes a byte or 16-bit word access as one or two byte phases. For each access it returns a single-cycle acknowledge, so the core can insert wait states. It replaces the zero-latency pass-through controller wherever memory read latency is non-zero.

## Interface
- AW, 20, address width; memory space 2^AW bytes
- LAT, 2, read latency in cycles, legal 1..8; out of range is an elaboration error
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_req  in  1  request strobe, sampled only in IDLE
- i_addr  in  AW  byte address of access
- i_word  in  1  1 = 16-bit access (low byte at i_addr), 0 = byte
- i_write  in  1  1 = write, 0 = read
- i_data  in  16  write data; byte access uses [7:0]
- o_busy  out  1  high from cycle after acceptance through ack cycle
- o_ack  out  1  one-cycle pulse, access complete
- o_data  out  16  read result, valid from ack cycle until next read ack
- i_mem_data  in  8  memory read data
- o_mem_addr  out  AW  memory address
- o_mem_data  out  8  memory write data
- o_mem_write  out  1  memory write strobe, one cycle per written byte

## Operation
- States: IDLE, WR, RD_WAIT, ACK. A phase bit (0 = low byte at addr, 1 = high byte at addr+1) and a latency counter of $clog2(LAT+1) bits accompany the state.
- IDLE: i_req=1 captures addr/word/write/data and clears phase. Next state is WR or RD_WAIT.
- WR: o_mem_addr = addr+phase, o_mem_data = data byte, o_mem_write=1 for exactly this cycle. If word and phase=0, go to phase 1 and stay in WR; otherwise go to ACK.
- RD_WAIT: o_mem_addr = addr+phase, held for LAT cycles. At the rising edge ending the LAT-th cycle, i_mem_data is latched into o_data[7:0] (phase 0) or o_data[15:8] (phase 1). After phase 0 of a word, re-enter RD_WAIT for phase 1 with the counter reloaded; otherwise go to ACK.
- Byte read clears o_data[15:8]. Writes never modify o_data.
- ACK: o_ack=1, then return to IDLE.
- Address arithmetic is modulo 2^AW. A word at 2^AW-1 takes its high byte from address 0.
- i_req while o_busy=1 is ignored, with no queueing. The requester re-issues after ack; i_req in the ack cycle is ignored.
- Outside WR, o_mem_write=0. In IDLE and ACK, o_mem_addr and o_mem_data hold their last values.
- Reset mid-access: all state and outputs return to reset values immediately. The access is abandoned with no ack, and a write strobe in progress drops asynchronously.

## Timing
- Reset values: o_busy=0, o_ack=0, o_data=0, o_mem_addr=0, o_mem_data=0, o_mem_write=0, state IDLE.
- Request sampled at edge T (end of idle cycle). The first memory cycle is T+1.
- Byte write: strobe in T+1, ack in T+2.
- Word write: strobes in T+1 and T+2, ack in T+3.
- Byte read: address in T+1..T+LAT, sample at end of T+LAT, ack in T+LAT+1.
- Word read: second address in T+LAT+1..T+2·LAT, ack in T+2·LAT+1.
- Back-to-back: the earliest next acceptance is the edge ending the cycle after ack.

## Structure
- Shared package mem_pkg holds the state enum (IDLE, WR, RD_WAIT, ACK) and the constant MEM_LAT_MAX=8 used by the parameter check.
- No sub-module. The counter and phase logic stay inline; the datapath is small and tightly coupled to the FSM.

## Test plan
- LAT=2, byte read at 0x12345 with memory 0xA5 → o_data=0x00A5, ack at T+3, busy T+1..T+3.
- Word write 0xBEEF at 0x00010 → strobe at 0x00010 with 0xEF in T+1 and at 0x00011 with 0xBE in T+2, ack T+3.
- Word read at 0xFFFFF with [0xFFFFF]=0x34, [0x00000]=0x12 → o_data=0x1234, ack T+5; repeat with LAT=1 (ack T+3) and LAT=8 (ack T+17).
- i_req pulsed repeatedly while busy and in the ack cycle → no extra memory cycles; exactly one ack per accepted request.
- rst_n asserted during the second phase of a word write → o_mem_write drops at once, all outputs zero, no ack; a fresh request after release completes normally.
